// File: rtl/instr_register_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_register_pkg                                           |
// | Description : Shared types for the instruction register and the fetch      |
// |               unit that drains it: opcode, operand/result, address,        |
// |               instruction word, FIFO entry and fetch FSM state.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  // One FIFO slot: the captured word plus the location it came from.
  typedef struct packed {
    instruction_t instr;
    address_t     addr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Park value for the read pointer while in reset.
  localparam address_t READ_POINTER_RESET = 5'h1F;

  // Register-file addresses wrap modulo 32 (31 -> 0) through natural overflow.
  function automatic address_t next_address(input address_t addr);
    return addr + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fifo                                                   |
// | Description : Synchronous FIFO, DEPTH entries of ENTRY_T, registered       |
// |               storage with the head presented combinationally from it.     |
// |               A push into a full FIFO is accepted when a pop happens in    |
// |               the same cycle.                                              |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               push / push_data   - write side                              |
// |               pop  / head        - read side (head valid when !empty)      |
// |               full, empty, count - occupancy                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fifo
  import instr_register_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  ENTRY_T                   push_data,
  input  logic                     pop,
  output ENTRY_T                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ENTRY_T             mem_q   [DEPTH];
  ENTRY_T             mem_d   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               push_ok;
  logic               pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // When full, the write slot aliases the head; overwriting it is safe only
  // because the head is being consumed on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Sequencer that walks read_pointer over N consecutive         |
// |               instruction-register locations, captures each word into a    |
// |               small FIFO and hands entries downstream over valid/ready.    |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               start, start_addr, num_instr - request (sampled in IDLE)     |
// |               read_pointer, instruction_word - register-file read port     |
// |               out_valid, out_ready, out_instr, out_addr - output stream    |
// |               busy (FETCH/DRAIN), done (one-cycle completion pulse)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   num_instr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instr,
  output address_t     out_addr,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_q,        state_d;
  address_t         read_pointer_q, read_pointer_d;
  logic [5:0]       remaining_q,    remaining_d;
  logic             done_q,         done_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign pop  = !fifo_empty && out_ready;
  // A full FIFO still takes a capture when the head leaves on the same edge,
  // which is what keeps throughput at one entry per cycle.
  assign push = (state_q == FETCH) && (!fifo_full || pop);

  assign push_entry = '{instr: instruction_word, addr: read_pointer_q};

  instr_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_instr != 6'd0) begin
            state_d        = FETCH;
            read_pointer_d = start_addr;
            remaining_d    = num_instr;
          end else begin
            // Empty request completes immediately without leaving IDLE.
            done_d = 1'b1;
          end
        end
      end

      FETCH: begin
        if (push) begin
          read_pointer_d = next_address(read_pointer_q);
          remaining_d    = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // No pushes happen here, so a pop with one entry left empties it.
        if (pop && (fifo_count == CNT_W'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      read_pointer_q <= READ_POINTER_RESET;
      remaining_q    <= 6'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      done_q         <= done_d;
    end
  end

  assign read_pointer = read_pointer_q;
  assign out_valid    = !fifo_empty;
  assign out_instr    = head_entry.instr;
  assign out_addr     = head_entry.addr;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit. A 32-entry array   |
// |               stands in for the instruction register; the expected stream |
// |               for each request is the list of (start+i) mod 32 locations.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;
  import instr_register_pkg::*;

  localparam int DEPTH    = 4;
  localparam int M_READY  = 0;
  localparam int M_RAND   = 1;
  localparam int M_STALL  = 2;
  localparam int M_INJECT = 3;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic         start      = 1'b0;
  address_t     start_addr = '0;
  logic [5:0]   num_instr  = '0;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready  = 1'b0;
  instruction_t out_instr;
  address_t     out_addr;
  logic         busy;
  logic         done;

  instruction_t regfile [32];
  fetch_entry_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign instruction_word = regfile[read_pointer];

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .num_instr        (num_instr),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_addr         (out_addr),
    .busy             (busy),
    .done             (done)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instruction_t rand_instr();
    instruction_t w;
    w.opc    = opcode_t'(4'($urandom_range(0, 7)));
    w.op_a   = $urandom;
    w.op_b   = $urandom;
    w.result = {$urandom, $urandom};
    return w;
  endfunction

  // Scoreboard: whenever a head is offered it must be the oldest outstanding
  // location, which also proves it holds still while stalled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        check_eq("pending", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          check_eq("out_addr", 256'(out_addr), 256'(exp_q[0].addr));
          check_eq("out_instr", 256'(out_instr), 256'(exp_q[0].instr));
          if (out_ready) begin
            void'(exp_q.pop_front());
          end
        end
        if (out_ready) pops++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_fetch(input address_t a, input int n, input int mode);
    fetch_entry_t e;
    int edges;
    int pops0;
    int done0;
    bit seen;
    for (int i = 0; i < n; i++) begin
      e.addr  = address_t'(32'(a) + i);
      e.instr = regfile[e.addr];
      exp_q.push_back(e);
    end
    pops0 = pops;
    done0 = done_cnt;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = a;
    num_instr  = 6'(n);
    out_ready  = (mode == M_RAND) ? 1'($urandom_range(0, 1)) : (mode != M_STALL);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 400) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (mode == M_STALL && edges == 9) begin
          check_eq("rp_frozen", 256'(read_pointer), 256'(address_t'(32'(a) + 4)));
          check_eq("stall_valid", 256'(out_valid), 256'(1));
        end
        @(posedge clk); #1;
        edges++;
        if (mode == M_RAND) out_ready = 1'($urandom_range(0, 1));
        if (mode == M_STALL) out_ready = (edges >= 10);
        if (mode == M_INJECT) begin
          start      = (edges == 1);
          start_addr = address_t'(32'(a) + 13);
          num_instr  = 6'd3;
        end
      end
    end
    check_eq("done_seen", 256'(seen), 256'(1));
    if (n == 0) check_eq("busy_zero_len", 256'(busy), 256'(0));
    // Without stalls, done is n+1 edges past the start-sampling edge
    // (N+2 cycles counted from the start cycle); an empty request is next cycle.
    if (mode == M_READY || mode == M_INJECT)
      check_eq("done_latency", 256'(edges), 256'((n == 0) ? 0 : n + 1));
    @(posedge clk); #1;
    @(negedge clk); #1;
    check_eq("done_single", 256'(done), 256'(0));
    check_eq("busy_after", 256'(busy), 256'(0));
    check_eq("done_count", 256'(done_cnt - done0), 256'(1));
    check_eq("pop_count", 256'(pops - pops0), 256'(n));
    check_eq("all_delivered", 256'(exp_q.size()), 256'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    fetch_entry_t e;
    for (int i = 0; i < 32; i++) regfile[i] = rand_instr();
    regfile[0] = '{opc: ADD,  op_a: 5,  op_b: 3, result: 8};
    regfile[1] = '{opc: SUB,  op_a: -2, op_b: 4, result: -6};
    regfile[2] = '{opc: MULT, op_a: 3,  op_b: 3, result: 9};
    regfile[3] = '{opc: ZERO, op_a: 0,  op_b: 0, result: 0};

    // Reset state
    #12;
    check_eq("rst_rp", 256'(read_pointer), 256'(5'h1F));
    check_eq("rst_valid", 256'(out_valid), 256'(0));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_done", 256'(done), 256'(0));
    check_eq("rst_out_addr", 256'(out_addr), 256'(0));
    check_eq("rst_out_instr", 256'(out_instr), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run_fetch(5'd0, 4, M_READY);                          // basic fetch
    run_fetch(5'd30, 4, M_READY);                         // wrap-around
    run_fetch(address_t'($urandom_range(0, 31)), 8, M_STALL);
    run_fetch(address_t'($urandom_range(0, 31)), 0, M_READY);
    run_fetch(address_t'($urandom_range(0, 31)), 8, M_INJECT);

    // Reset mid-operation after two captures
    for (int i = 0; i < 6; i++) begin
      e.addr  = address_t'(5 + i);
      e.instr = regfile[e.addr];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = 5'd5; num_instr = 6'd6; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 256'(out_valid), 256'(0));
    check_eq("mid_rst_busy", 256'(busy), 256'(0));
    check_eq("mid_rst_rp", 256'(read_pointer), 256'(31));
    check_eq("mid_rst_done", 256'(done), 256'(0));
    exp_q.delete();
    @(negedge clk); #2;
    reset_n = 1'b1;
    run_fetch(5'd10, 2, M_READY);

    // Full sweeps with random backpressure
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) regfile[i] = rand_instr();
      run_fetch(address_t'($urandom_range(0, 31)), 32, M_RAND);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Downstream consumer of the instruction register. On `start` it walks `read_pointer` through N consecutive register locations from a start address, captures each `instruction_word` into a small internal FIFO, and presents the entries to the next stage over a valid/ready handshake with full backpressure. It replaces the bench-driven read loop with a synthesizable sequencer.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.
- `clk` input, 1 bit: single clock; all state updates on posedge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: single-cycle request; sampled only in IDLE.
- `start_addr` input, `address_t` (5 bits): first location to read; sampled with `start`.
- `num_instr` input, 6 bits: number of reads, 0..32; sampled with `start`.
- `read_pointer` output, `address_t`: address driven to the instruction register.
- `instruction_word` input, `instruction_t`: combinational read data for `read_pointer`, valid in the same cycle.
- `out_valid` output, 1 bit: FIFO head is valid.
- `out_ready` input, 1 bit: consumer accepts the head.
- `out_instr` output, `instruction_t`: FIFO head data.
- `out_addr` output, `address_t`: source location of the head.
- `busy` output, 1 bit: high in FETCH and DRAIN.
- `done` output, 1 bit: one-cycle pulse when the last entry is accepted.

## Operation
- **States:** IDLE, FETCH, DRAIN, stored as `fetch_state_t`.
- **IDLE:**
  - `start=1` and `num_instr>0`: latch `start_addr` into `read_pointer`, load `remaining=num_instr`, go to FETCH.
  - `start=1` and `num_instr=0`: pulse `done` next cycle and stay in IDLE.
  - `start` is ignored in any state other than IDLE.
- **FETCH:** each cycle with push enabled:
  - Write `{instruction_word, read_pointer}` to the FIFO.
  - `read_pointer <= read_pointer+1`, modulo 32, so 31 wraps to 0.
  - `remaining--`.
  - When `remaining` reaches 0, go to DRAIN.
- **Push enable:** `count<DEPTH`, or `count==DEPTH` and a pop occurs in the same cycle. A stall holds `read_pointer` unchanged.
- **Pop:** `out_valid && out_ready`. `count` is unchanged when push and pop happen together.
- **DRAIN:** when the FIFO empties through a pop, pulse `done` and go to IDLE.
- **Data integrity:** `out_instr` fields (`opc`, `op_a`, `op_b`, `result`) are passed through bit-exact with no arithmetic. FIFO pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
- **Handshake rule:** while `out_valid=1` and `out_ready=0`, `out_instr` and `out_addr` hold stable.
- **Reset** (asynchronous, any time including mid-fetch):
  - State goes to IDLE; FIFO is emptied.
  - `read_pointer=5'h1F`, `out_valid=0`, `out_instr='0`, `out_addr=0`, `busy=0`, `done=0`, `remaining=0`.

## Timing
- The first capture happens at the posedge following the one that accepted `start`.
- `out_valid` rises 1 cycle after the first capture (registered FIFO output).
- With `out_ready` held high, throughput is 1 entry per cycle. `done` asserts in the cycle after the last pop.
- Minimum `start`→`done` for N reads with no stalls: N+2 cycles.
- `read_pointer` changes only on posedge, so the register file's combinational read settles within the cycle.

## Structure
- **Shared package:** `fetch_state_t` (IDLE/FETCH/DRAIN) and a `fetch_entry_t` struct `{instruction_t instr; address_t addr;}` go in `instr_register_pkg`, next to `instruction_t`, `address_t` and `opcode_t`.
- **Sub-module:** one `instr_fifo`, a synchronous FIFO parameterized by `DEPTH` and entry type. It exposes push/pop/full/empty/count and uses the same asynchronous active-low `reset_n`. The FSM and pointer logic stay in `instr_fetch_unit`.

## Test plan
- **Basic fetch:** preload locations 0..3 with `{ADD,5,3,8}`, `{SUB,-2,4,-6}`, `{MULT,3,3,9}`, `{ZERO,0,0,0}`; `start_addr=0`, `num_instr=4`, `out_ready=1`.
  - Four entries with `out_addr` 0,1,2,3 and identical fields.
  - `done` pulses exactly once at cycle 6 after `start`.
- **Wrap-around:** `start_addr=30`, `num_instr=4`.
  - `out_addr` sequence is 30,31,0,1.
- **Backpressure:** `num_instr=8`, `DEPTH=4`, `out_ready=0` for 10 cycles, then 1.
  - `read_pointer` freezes at `start_addr+4`.
  - `out_instr` stays stable while stalled.
  - All 8 entries are delivered in order with none lost or duplicated.
- **Zero length and ignored start:**
  - `num_instr=0`: `done` pulses one cycle later, `busy` stays 0.
  - `start` pulsed during FETCH: ignored, and the address sequence is unaffected.
- **Reset mid-operation:** assert `reset_n=0` asynchronously, between edges, after 2 of 6 reads.
  - Immediately: `out_valid=0`, `busy=0`, `read_pointer=31`.
  - After release, a new `start` with `start_addr=10`, `num_instr=2` returns addresses 10,11 only.
- **Full 32-read sweep:** random `out_ready` and 32 random preloaded entries.
  - Scoreboard matches all 32 `{opc, op_a, op_b, result}` values.
  - Exactly 32 pops and exactly one `done` pulse.
